// File: rtl/obstacle_sched.sv
// obstacle_sched: spawns falling obstacles into fixed slots, moves them each frame,
// and turns gun shots into hit pulses and floor crossings into miss pulses.
module obstacle_sched #(
    parameter int          N_OBS      = 4,
    parameter int          OBS_SIZE   = 16,
    parameter int          MAX_X      = 640,
    parameter int          GUN_Y_T    = 429,
    parameter int          SPAWN_BASE = 64,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refr_tick,
    input  logic       run,
    input  logic [1:0] level,
    input  logic       shot,
    input  logic [9:0] shot_x,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       obs_on,
    output logic       hit,
    output logic       miss,
    output logic [3:0] active_cnt
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [9:0] SZ   = 10'(OBS_SIZE);
    localparam logic [9:0] GY   = 10'(GUN_Y_T);
    localparam logic [9:0] XLIM = 10'(MAX_X - OBS_SIZE);

    state_t           state, state_n;
    logic [N_OBS-1:0] valid, valid_n, kill;
    logic [9:0]       ox [N_OBS];
    logic [9:0]       oy [N_OBS];
    logic [9:0]       ox_n [N_OBS];
    logic [9:0]       oy_n [N_OBS];
    logic [9:0]       timer, timer_n, period, step, spawn_x, ny, best;
    logic [15:0]      lfsr;
    logic             hit_n, miss_n, placed, wrap;

    assign period  = 10'(SPAWN_BASE >> level);
    assign step    = 10'(level) + 10'd1;
    assign wrap    = timer >= period - 10'd1;
    assign spawn_x = (lfsr[9:0] > XLIM) ? lfsr[9:0] - 10'd512 : lfsr[9:0];

    // Shot target: covering slot with the largest oy; strict compare keeps the lowest index on ties
    always_comb begin
        kill = '0;
        best = '0;
        for (int i = 0; i < N_OBS; i++)
            if (shot && valid[i] && shot_x >= ox[i] && shot_x - ox[i] < SZ &&
                (kill == '0 || oy[i] > best)) begin
                kill    = '0;
                kill[i] = 1'b1;
                best    = oy[i];
            end
    end

    always_comb begin
        state_n = state;
        valid_n = valid;
        ox_n    = ox;
        oy_n    = oy;
        timer_n = timer;
        hit_n   = 1'b0;
        miss_n  = 1'b0;
        ny      = '0;
        placed  = 1'b0;
        if (state == IDLE) begin
            valid_n = '0;
            timer_n = '0;
            state_n = run ? ACTIVE : IDLE;
        end else if (!run) begin
            state_n = IDLE;
            valid_n = '0;
            timer_n = '0;
        end else begin
            valid_n = valid & ~kill;
            hit_n   = |kill;
            if (refr_tick) begin
                for (int i = 0; i < N_OBS; i++)
                    if (valid_n[i]) begin
                        ny = oy[i] + step;
                        if (ny + SZ > GY) begin
                            valid_n[i] = 1'b0;
                            miss_n     = 1'b1;
                        end else
                            oy_n[i] = ny;
                    end
                timer_n = wrap ? '0 : timer + 10'd1;
                // Spawn runs after the move so the newcomer stays at row 0 this frame
                if (wrap)
                    for (int i = 0; i < N_OBS; i++)
                        if (!placed && !valid_n[i]) begin
                            placed     = 1'b1;
                            valid_n[i] = 1'b1;
                            ox_n[i]    = spawn_x;
                            oy_n[i]    = '0;
                        end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            timer      <= '0;
            lfsr       <= LFSR_SEED;
            hit        <= 1'b0;
            miss       <= 1'b0;
            active_cnt <= '0;
            for (int i = 0; i < N_OBS; i++) begin
                ox[i] <= '0;
                oy[i] <= '0;
            end
        end else begin
            state      <= state_n;
            valid      <= valid_n;
            timer      <= timer_n;
            lfsr       <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            hit        <= hit_n;
            miss       <= miss_n;
            active_cnt <= 4'($countones(valid));
            ox         <= ox_n;
            oy         <= oy_n;
        end
    end

    always_comb begin
        obs_on = 1'b0;
        for (int i = 0; i < N_OBS; i++)
            if (valid[i] && x >= ox[i] && x - ox[i] < SZ && y >= oy[i] && y - oy[i] < SZ)
                obs_on = 1'b1;
    end
endmodule
